// File: rtl/fetcher.sv
// Instruction fetcher: issues one icache request at a time, hands each returned word to the
// branch predictor, and pushes it to the instruction queue. Define FETCH_BR_PREDICT_EN to trust pd_tk.
module fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        ic_req,
    output logic [31:0] ic_pc,
    input  logic        ic_valid,
    input  logic [31:0] ic_inst,
    output logic [31:0] pd_pc,
    output logic [31:0] pd_inst,
    input  logic        pd_tk,
    input  logic [31:0] pd_off,
    input  logic        iq_full,
    output logic        iq_push,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_tk,
    input  logic        fl_ena,
    input  logic [31:0] fl_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;

    logic [31:0] cur_inst;
    logic        eff_tk;
    logic [31:0] next_pc;
    logic        req;
    logic        push;

    // The word under consideration: live response while waiting, buffered copy otherwise.
    assign cur_inst = (state_q == S_WAIT) ? ic_inst : buf_q;

`ifdef FETCH_BR_PREDICT_EN
    assign eff_tk = pd_tk;
`else
    // Static policy: only unconditional JAL redirects; conditional branches fall through.
    logic unused_pd_tk;
    assign unused_pd_tk = pd_tk;
    assign eff_tk = (cur_inst[6:0] == 7'h6f);
`endif

    assign next_pc = eff_tk ? (pc_q + pd_off) : (pc_q + 32'd4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        req     = 1'b0;
        push    = 1'b0;
        if (rdy) begin
            if (fl_ena) begin
                // A request already in flight must be absorbed before refetching.
                pc_d = fl_pc;
                case (state_q)
                    S_WAIT:  state_d = ic_valid ? S_REQ : S_DROP;
                    S_DROP:  state_d = ic_valid ? S_REQ : S_DROP;
                    default: state_d = S_REQ;
                endcase
            end else begin
                case (state_q)
                    S_REQ: begin
                        req     = 1'b1;
                        state_d = S_WAIT;
                    end
                    S_WAIT: begin
                        if (ic_valid) begin
                            if (!iq_full) begin
                                push    = 1'b1;
                                pc_d    = next_pc;
                                state_d = S_REQ;
                            end else begin
                                buf_d   = ic_inst;
                                state_d = S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!iq_full) begin
                            push    = 1'b1;
                            pc_d    = next_pc;
                            state_d = S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (ic_valid) state_d = S_REQ;
                    end
                    default: state_d = S_REQ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    assign ic_req  = req & ~rst;
    assign ic_pc   = pc_q;
    assign pd_pc   = pc_q;
    assign pd_inst = rst ? 32'h0 : cur_inst;
    assign iq_push = push & ~rst;
    assign iq_inst = iq_push ? cur_inst : 32'h0;
    assign iq_pc   = iq_push ? pc_q : 32'h0;
    assign iq_tk   = iq_push & eff_tk;

endmodule
